// File: rtl/button_pattern_loader.sv
// Button/switch front end for the rotating-LED display: sync, debounce, edge-detect, act.
// Optional macro PATTERN_ZERO_GUARD_EN replaces an all-zero loaded pattern with 8'h01.
module button_pattern_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic       btn_load,
    input  logic       btn_dir,
    input  logic       btn_speed,
    output logic [7:0] pattern,
    output logic       load_pulse,
    output logic       dir,
    output logic [1:0] speed_sel
);

    localparam int unsigned NB = 3;
    localparam int unsigned B_LOAD  = 0;
    localparam int unsigned B_DIR   = 1;
    localparam int unsigned B_SPEED = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [7:0]       sw_s1_q, sw_s2_q;
    logic [NB-1:0]    btn_s1_q, btn_s2_q;
    logic [NB-1:0]    stable_q, stable_d;
    logic [NB-1:0]    stable_dly_q;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [NB-1:0]    rise;

    logic [7:0] pattern_q, pattern_d;
    logic       load_pulse_q, load_pulse_d;
    logic       dir_q, dir_d;
    logic [1:0] speed_q, speed_d;
    logic [7:0] load_value;

    // Any sample that matches the accepted level restarts the count, so a single bounce resets it.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (btn_s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign rise = stable_q & ~stable_dly_q;

`ifdef PATTERN_ZERO_GUARD_EN
    assign load_value = (sw_s2_q == 8'h00) ? 8'h01 : sw_s2_q;
`else
    assign load_value = sw_s2_q;
`endif

    always_comb begin
        pattern_d    = pattern_q;
        load_pulse_d = rise[B_LOAD];
        dir_d        = dir_q ^ rise[B_DIR];
        speed_d      = speed_q + {1'b0, rise[B_SPEED]};
        if (rise[B_LOAD]) begin
            pattern_d = load_value;
        end
    end

    // NOTE: every state register uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            // NOTE: the counters are discrete flops, not a RAM, so clearing them on reset is legal and required.
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            pattern_q    <= 8'h01;
            load_pulse_q <= 1'b0;
            dir_q        <= 1'b0;
            speed_q      <= 2'd0;
        end else begin
            sw_s1_q      <= sw;
            sw_s2_q      <= sw_s1_q;
            btn_s1_q     <= {btn_speed, btn_dir, btn_load};
            btn_s2_q     <= btn_s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pattern_q    <= pattern_d;
            load_pulse_q <= load_pulse_d;
            dir_q        <= dir_d;
            speed_q      <= speed_d;
        end
    end

    assign pattern    = pattern_q;
    assign load_pulse = load_pulse_q;
    assign dir        = dir_q;
    assign speed_sel  = speed_q;

endmodule

// File: tb/tb_button_pattern_loader.sv
// Bench for button_pattern_loader: sliding-window debounce model plus directed literal checks.
module tb_button_pattern_loader;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       btn_load = 1'b0, btn_dir = 1'b0, btn_speed = 1'b0;
    logic [7:0] pattern;
    logic       load_pulse, dir;
    logic [1:0] speed_sel;

    int n_cmp = 0;
    int n_fail = 0;

    button_pattern_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(24)) dut (
        .clock(clock), .reset(reset), .sw(sw),
        .btn_load(btn_load), .btn_dir(btn_dir), .btn_speed(btn_speed),
        .pattern(pattern), .load_pulse(load_pulse), .dir(dir), .speed_sel(speed_sel)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] guard(input logic [7:0] v);
`ifdef PATTERN_ZERO_GUARD_EN
        return (v == 8'h00) ? 8'h01 : v;
`else
        return v;
`endif
    endfunction

    // Model: a button's accepted level flips once the synchronised input has shown the
    // opposite level for the last D whole cycles; the action lands one edge after the flip.
    logic [7:0] m_pattern, m_sw_s1, m_sw_s2;
    logic       m_lp, m_dir;
    logic [1:0] m_spd;
    logic       m_stable [3];
    logic       m_pend [3];
    logic       m_prev_raw [3];
    logic       s2h [3][$];
    logic       raw [3];
    logic       all_diff;
    bit         model_ready = 0;

    always @(posedge clock) begin
        raw = '{btn_load, btn_dir, btn_speed};
        if (reset) begin
            m_pattern = 8'h01; m_lp = 1'b0; m_dir = 1'b0; m_spd = 2'd0;
            m_sw_s1 = 8'h00; m_sw_s2 = 8'h00;
            for (int b = 0; b < 3; b++) begin
                m_stable[b] = 1'b0; m_pend[b] = 1'b0; m_prev_raw[b] = 1'b0;
                s2h[b].delete();
                s2h[b].push_back(1'b0);
            end
            model_ready = 1;
        end else begin
            m_lp = m_pend[0];
            if (m_pend[0]) m_pattern = guard(m_sw_s2);
            if (m_pend[1]) m_dir = ~m_dir;
            if (m_pend[2]) m_spd = m_spd + 2'd1;
            for (int b = 0; b < 3; b++) begin
                all_diff = (s2h[b].size() >= D);
                foreach (s2h[b][i]) if (s2h[b][i] == m_stable[b]) all_diff = 1'b0;
                m_pend[b] = all_diff && !m_stable[b];
                if (all_diff) m_stable[b] = ~m_stable[b];
                s2h[b].push_back(m_prev_raw[b]);
                if (s2h[b].size() > D) void'(s2h[b].pop_front());
                m_prev_raw[b] = raw[b];
            end
            m_sw_s2 = m_sw_s1;
            m_sw_s1 = sw;
        end
    end

    always @(negedge clock) begin
        if (model_ready) begin
            check("model_pattern", 32'(pattern), 32'(m_pattern));
            check("model_load_pulse", 32'(load_pulse), 32'(m_lp));
            check("model_dir", 32'(dir), 32'(m_dir));
            check("model_speed_sel", 32'(speed_sel), 32'(m_spd));
        end
    end

    // Steps n falling edges, counting load pulses; first_idx is the 0-based index of the first one.
    task automatic watch(input int n, output int cnt, output int first_idx);
        cnt = 0;
        first_idx = -1;
        for (int j = 0; j < n; j++) begin
            @(negedge clock);
            if (load_pulse === 1'b1) begin
                if (cnt == 0) first_idx = j;
                cnt++;
            end
        end
    endtask

    task automatic press_speed(input logic [1:0] exp);
        int c, idx;
        btn_speed = 1'b1;
        watch(8, c, idx);
        btn_speed = 1'b0;
        watch(10, c, idx);
        check("speed_step", 32'(speed_sel), 32'(exp));
    endtask

    initial begin
        int c, idx;
        logic [1:0] prev_spd;
        logic [1:0] spd_at_pulse;
        logic [7:0] pat_at_pulse;
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        watch(6, c, idx);
        check("reset_pattern", 32'(pattern), 32'h01);
        check("reset_dir", 32'(dir), 32'h0);
        check("reset_speed", 32'(speed_sel), 32'h0);
        check("idle_no_pulse", 32'(c), 32'd0);

        // Clean load of A5: pulse in the cycle after edge k+6.
        sw = 8'hA5;
        btn_load = 1'b1;
        watch(20, c, idx);
        check("load_pulse_index", 32'(idx), 32'd6);
        check("load_pulse_count", 32'(c), 32'd1);
        check("load_pattern_a5", 32'(pattern), 32'hA5);
        btn_load = 1'b0;
        watch(15, c, idx);
        check("release_no_pulse", 32'(c), 32'd0);

        // Short dir glitch, then two clean presses.
        btn_dir = 1'b1;
        watch(3, c, idx);
        btn_dir = 1'b0;
        watch(10, c, idx);
        check("dir_glitch_ignored", 32'(dir), 32'd0);
        btn_dir = 1'b1;
        watch(10, c, idx);
        btn_dir = 1'b0;
        watch(12, c, idx);
        check("dir_first_press", 32'(dir), 32'd1);
        btn_dir = 1'b1;
        watch(10, c, idx);
        btn_dir = 1'b0;
        watch(12, c, idx);
        check("dir_second_press", 32'(dir), 32'd0);

        for (int i = 0; i < 5; i++) press_speed(exp_seq[i]);

        // Simultaneous load and speed rises.
        sw = 8'h3C;
        btn_load = 1'b1;
        btn_speed = 1'b1;
        c = 0;
        prev_spd = speed_sel;
        spd_at_pulse = 2'd0;
        pat_at_pulse = 8'h00;
        idx = -1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            if (load_pulse === 1'b1 && c == 0) begin
                c = 1;
                idx = j;
                spd_at_pulse = speed_sel;
                pat_at_pulse = pattern;
            end
            if (c == 0) prev_spd = speed_sel;
        end
        check("simul_pulse_index", 32'(idx), 32'd6);
        check("simul_speed_before", 32'(prev_spd), 32'd1);
        check("simul_speed_at_pulse", 32'(spd_at_pulse), 32'd2);
        check("simul_pattern", 32'(pat_at_pulse), 32'h3C);
        btn_load = 1'b0;
        btn_speed = 1'b0;
        watch(12, c, idx);

        // Zero pattern load.
        sw = 8'h00;
        btn_load = 1'b1;
        watch(10, c, idx);
        check("zero_load_pulse", 32'(c), 32'd1);
        btn_load = 1'b0;
        watch(10, c, idx);
`ifdef PATTERN_ZERO_GUARD_EN
        check("zero_load_pattern", 32'(pattern), 32'h01);
`else
        check("zero_load_pattern", 32'(pattern), 32'h00);
`endif

        // Reset in the middle of a held load press.
        sw = 8'h5A;
        btn_load = 1'b1;
        watch(3, c, idx);
        check("pre_reset_no_pulse", 32'(c), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("reset_again_pattern", 32'(pattern), 32'h01);
        reset = 1'b0;
        watch(12, c, idx);
        check("post_reset_pulse_index", 32'(idx), 32'(D + 2));
        check("post_reset_pulse_count", 32'(c), 32'd1);
        check("post_reset_pattern", 32'(pattern), 32'h5A);
        btn_load = 1'b0;
        watch(12, c, idx);
        check("post_reset_release", 32'(c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
